zigbee_chip_spreader: RTL and testbench

- 802.15.4 2.4 GHz DSSS spreading stage, directly downstream of the TOP data path FIFO (4-bit nibble output, read-enable interface).
- Pops one 4-bit symbol per 32 chips and maps it to the standard 32-chip PN sequence.
- Emits the chips as 16 I/Q pairs: even chips on I, odd chips on Q, one pair every CHIP_DIV clocks.
- Prefetches the next symbol, so a non-empty FIFO gives a gapless chip stream. The half-chip Q offset and the modulator are downstream.

---
 rtl/zigbee_phy_pkg.sv | 34 +++
 rtl/chip_pair_serializer.sv | 77 +++++++
 rtl/zigbee_chip_spreader.sv | 111 +++++++++++
 tb/tb_zigbee_chip_spreader.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/zigbee_phy_pkg.sv
// Shared 802.15.4 2.4 GHz PHY definitions: chip sequence type, spreader states
// and the symbol-to-PN-sequence mapping (chip c0 held in bit 0).
package zigbee_phy_pkg;

  localparam int unsigned CHIPS_PER_SYM = 32;
  localparam int unsigned PAIRS_PER_SYM = 16;

  typedef logic [CHIPS_PER_SYM-1:0] chip_seq_t;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND
  } spreader_state_t;

  // Symbol 0 written c0-first is 1101 1001 1100 0011 0101 0010 0010 1110.
  localparam chip_seq_t SYM0_CHIPS    = 32'h744A_C39B;
  localparam chip_seq_t ODD_CHIP_MASK = 32'hAAAA_AAAA;

  // Rotating the chip stream right by 4s chips is a left rotate of the vector
  // because c0 sits in the LSB.
  function automatic chip_seq_t sym_to_chips(input logic [3:0] sym);
    logic [5:0] sh;
    chip_seq_t  rot;
    sh  = {1'b0, sym[2:0], 2'b00};
    rot = (SYM0_CHIPS << sh) | (SYM0_CHIPS >> (6'd32 - sh));
    if (sym[3]) begin
      rot = rot ^ ODD_CHIP_MASK;
    end
    return rot;
  endfunction

endpackage

// File: rtl/chip_pair_serializer.sv
// Shifts a 32-chip sequence out as 16 I/Q pairs, each held CHIP_DIV clocks.
// A load restarts pair 0 immediately, allowing gapless symbol chaining.
module chip_pair_serializer
  import zigbee_phy_pkg::*;
#(
  parameter int unsigned CHIP_DIV = 1,
  parameter int unsigned DIV_W    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  chip_seq_t  load_chips,
  output logic       chip_i,
  output logic       chip_q,
  output logic       valid,
  output logic       sym_start,
  output logic       pair_end,
  output logic [3:0] pair_idx
);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CHIP_DIV - 1);
  localparam logic [3:0]       PAIR_LAST = 4'(PAIRS_PER_SYM - 1);

  chip_seq_t        shift_q, shift_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       pair_q, pair_d;
  logic             active_q, active_d;

  always_comb begin
    shift_d  = shift_q;
    div_d    = div_q;
    pair_d   = pair_q;
    active_d = active_q;
    if (load) begin
      shift_d  = load_chips;
      div_d    = '0;
      pair_d   = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        if (pair_q == PAIR_LAST) begin
          active_d = 1'b0;
          pair_d   = '0;
          shift_d  = '0;
        end else begin
          pair_d  = pair_q + 4'd1;
          shift_d = shift_q >> 2;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      div_q    <= '0;
      pair_q   <= '0;
      active_q <= 1'b0;
    end else begin
      shift_q  <= shift_d;
      div_q    <= div_d;
      pair_q   <= pair_d;
      active_q <= active_d;
    end
  end

  assign chip_i    = active_q & shift_q[0];
  assign chip_q    = active_q & shift_q[1];
  assign valid     = active_q;
  assign sym_start = active_q & (pair_q == '0) & (div_q == '0);
  assign pair_end  = active_q & (div_q == DIV_LAST);
  assign pair_idx  = pair_q;

endmodule

// File: rtl/zigbee_chip_spreader.sv
// 802.15.4 DSSS spreader: pops FIFO nibbles, maps them to PN chips and emits
// I/Q chip pairs, prefetching the next symbol during pair 14 for gapless output.
module zigbee_chip_spreader
  import zigbee_phy_pkg::*;
#(
  parameter int unsigned CHIP_DIV = 1,
  parameter int unsigned DIV_W    = 8
) (
  input  logic       inClock,
  input  logic       inReset,
  input  logic       inEnable,
  input  logic       inEmpty,
  input  logic [3:0] inData,
  output logic       outReadEnable,
  output logic       outChipI,
  output logic       outChipQ,
  output logic       outChipValid,
  output logic       outSymbolStart,
  output logic       outBusy
);

  spreader_state_t state_q, state_d;
  logic [3:0]      pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;
  logic            inflight_q, inflight_d;
  logic            rd_en;
  logic            ser_load;
  logic [3:0]      load_nib;
  logic            ser_pair_end;
  logic [3:0]      ser_pair;

  always_comb begin
    state_d      = state_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    inflight_d   = 1'b0;
    rd_en        = 1'b0;
    ser_load     = 1'b0;
    load_nib     = inData;
    if (inflight_q) begin
      pend_d       = inData;
      pend_valid_d = 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (inEnable && !inEmpty) state_d = FETCH;
      end
      FETCH: begin
        rd_en   = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        ser_load = 1'b1;
        state_d  = SEND;
      end
      SEND: begin
        if (ser_pair_end && ser_pair == 4'd14 && inEnable && !inEmpty) begin
          rd_en      = 1'b1;
          inflight_d = 1'b1;
        end
        // With CHIP_DIV=1 the prefetched word arrives on the very last clock,
        // so it is taken straight from inData rather than the pending register.
        if (ser_pair_end && ser_pair == 4'd15) begin
          if (inflight_q || pend_valid_q) begin
            ser_load     = 1'b1;
            load_nib     = inflight_q ? inData : pend_q;
            pend_valid_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (inReset) rd_en = 1'b0;
  end

  always_ff @(posedge inClock) begin
    if (inReset) begin
      state_q      <= IDLE;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      inflight_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      inflight_q   <= inflight_d;
    end
  end

  chip_pair_serializer #(
    .CHIP_DIV(CHIP_DIV),
    .DIV_W   (DIV_W)
  ) u_ser (
    .clk       (inClock),
    .rst       (inReset),
    .load      (ser_load),
    .load_chips(sym_to_chips(load_nib)),
    .chip_i    (outChipI),
    .chip_q    (outChipQ),
    .valid     (outChipValid),
    .sym_start (outSymbolStart),
    .pair_end  (ser_pair_end),
    .pair_idx  (ser_pair)
  );

  assign outReadEnable = rd_en;
  assign outBusy       = (state_q != IDLE);

endmodule

// File: tb/tb_zigbee_chip_spreader.sv
// Self-checking bench: per-cycle expected waveforms built from the symbol/chip
// rules, compared against two instances (CHIP_DIV=1 and CHIP_DIV=4).
module tb_zigbee_chip_spreader;

  localparam int unsigned MAXC = 128;

  logic clk = 1'b0;
  logic inReset = 1'b1;
  logic inEnable = 1'b1;
  logic empty1 = 1'b1, empty4 = 1'b1;
  logic [3:0] data1 = '0, data4 = '0;
  logic rd1, ci1, cq1, v1, st1, b1;
  logic rd4, ci4, cq4, v4, st4, b4;

  zigbee_chip_spreader #(.CHIP_DIV(1), .DIV_W(8)) dut1 (
    .inClock(clk), .inReset(inReset), .inEnable(inEnable), .inEmpty(empty1),
    .inData(data1), .outReadEnable(rd1), .outChipI(ci1), .outChipQ(cq1),
    .outChipValid(v1), .outSymbolStart(st1), .outBusy(b1)
  );

  zigbee_chip_spreader #(.CHIP_DIV(4), .DIV_W(8)) dut4 (
    .inClock(clk), .inReset(inReset), .inEnable(inEnable), .inEmpty(empty4),
    .inData(data4), .outReadEnable(rd4), .outChipI(ci4), .outChipQ(cq4),
    .outChipValid(v4), .outSymbolStart(st4), .outBusy(b4)
  );

  always #5 clk = ~clk;

  logic [3:0] fifo1[$];
  logic [3:0] fifo4[$];
  bit exp_v[MAXC], exp_i[MAXC], exp_q[MAXC], exp_s[MAXC], exp_r[MAXC], exp_b[MAXC];
  bit obs_v[MAXC], obs_i[MAXC], obs_q[MAXC], obs_s[MAXC], obs_r[MAXC], obs_b[MAXC];
  bit drv_en[MAXC], drv_rst[MAXC];
  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned tcyc = 0;
  bit chk_on = 1'b0;
  bit sel = 1'b0;

  task automatic chk(input string name, input int unsigned c,
                     input int unsigned got, input int unsigned exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", name, c, got, exp);
    end
  endtask

  // Chip i of symbol s, from the c0-first written form of symbol 0.
  function automatic bit chip_of(input int unsigned s, input int unsigned i);
    logic [31:0] base;
    int unsigned j;
    bit b;
    base = 32'b11011001110000110101001000101110;
    j = (i + 32 - 4 * (s % 8)) % 32;
    b = base[31 - j];
    if (s >= 8 && (i % 2) == 1) b = ~b;
    return b;
  endfunction

  task automatic clear_from(input int unsigned t0);
    for (int unsigned t = t0; t < MAXC; t++) begin
      exp_v[t] = 0; exp_i[t] = 0; exp_q[t] = 0;
      exp_s[t] = 0; exp_r[t] = 0; exp_b[t] = 0;
    end
  endtask

  // Decision (enable & !empty in IDLE) at cycle t0; n symbols s0,s1,s2 follow back to back.
  task automatic add_burst(input int unsigned d, input int unsigned s0, input int unsigned s1,
                           input int unsigned s2, input int unsigned n, input int unsigned t0);
    int unsigned syms[3];
    int unsigned st, t;
    syms[0] = s0; syms[1] = s1; syms[2] = s2;
    exp_r[t0 + 1] = 1;
    for (int unsigned t2 = t0 + 1; t2 <= t0 + 2 + 16 * d * n; t2++) exp_b[t2] = 1;
    for (int unsigned j = 0; j < n; j++) begin
      st = t0 + 3 + j * 16 * d;
      for (int unsigned k = 0; k < 16; k++) begin
        for (int unsigned m = 0; m < d; m++) begin
          t = st + k * d + m;
          exp_v[t] = 1;
          exp_i[t] = chip_of(syms[j], 2 * k);
          exp_q[t] = chip_of(syms[j], 2 * k + 1);
          exp_s[t] = (k == 0 && m == 0);
        end
      end
      if (j + 1 < n) exp_r[st + 15 * d - 1] = 1;
    end
  endtask

  task automatic new_test();
    clear_from(0);
    for (int unsigned c = 0; c < MAXC; c++) begin
      drv_en[c] = 1; drv_rst[c] = 0;
      obs_v[c] = 0; obs_i[c] = 0; obs_q[c] = 0;
      obs_s[c] = 0; obs_r[c] = 0; obs_b[c] = 0;
    end
  endtask

  // FIFO model: data appears the cycle after a sampled read enable.
  task automatic step(input int unsigned c);
    bit ra, rb;
    @(negedge clk);
    ra = rd1; rb = rd4;
    @(posedge clk);
    #1;
    if (ra && fifo1.size() > 0) data1 = fifo1.pop_front();
    if (rb && fifo4.size() > 0) data4 = fifo4.pop_front();
    empty1 = (fifo1.size() == 0);
    empty4 = (fifo4.size() == 0);
    inEnable = drv_en[c];
    inReset = drv_rst[c];
    tcyc = c;
  endtask

  task automatic run_window(input int unsigned len);
    for (int unsigned c = 0; c < len; c++) begin
      step(c);
      if (c == 0) chk_on = 1'b1;
    end
    @(negedge clk);
    #1 chk_on = 1'b0;
  endtask

  function automatic int unsigned count_v(input int unsigned a, input int unsigned b);
    int unsigned n = 0;
    for (int unsigned t = a; t <= b; t++) n += obs_v[t];
    return n;
  endfunction

  function automatic int unsigned count_sr(input bit use_r);
    int unsigned n = 0;
    for (int unsigned t = 0; t < MAXC; t++) n += use_r ? obs_r[t] : obs_s[t];
    return n;
  endfunction

  always @(negedge clk) begin
    if (chk_on) begin
      obs_v[tcyc] = sel ? v4 : v1;
      obs_i[tcyc] = sel ? ci4 : ci1;
      obs_q[tcyc] = sel ? cq4 : cq1;
      obs_s[tcyc] = sel ? st4 : st1;
      obs_r[tcyc] = sel ? rd4 : rd1;
      obs_b[tcyc] = sel ? b4 : b1;
      chk("valid", tcyc, obs_v[tcyc], exp_v[tcyc]);
      chk("chip_i", tcyc, obs_i[tcyc], exp_i[tcyc]);
      chk("chip_q", tcyc, obs_q[tcyc], exp_q[tcyc]);
      chk("sym_start", tcyc, obs_s[tcyc], exp_s[tcyc]);
      chk("read_en", tcyc, obs_r[tcyc], exp_r[tcyc]);
      chk("busy", tcyc, obs_b[tcyc], exp_b[tcyc]);
    end
  end

  initial begin
    // Reset held 5 cycles, then single symbol 0x0.
    new_test();
    sel = 1'b0;
    fifo1.push_back(4'h0);
    for (int unsigned c = 0; c < 5; c++) drv_rst[c] = 1;
    add_burst(1, 0, 0, 0, 1, 5);
    run_window(28);
    chk("rst_read", 4, obs_r[4], 0);
    chk("first_read", 6, obs_r[6], 1);
    chk("sym0_p0_i", 8, obs_i[8], 1);  chk("sym0_p0_q", 8, obs_q[8], 1);
    chk("sym0_p1_i", 9, obs_i[9], 0);  chk("sym0_p1_q", 9, obs_q[9], 1);
    chk("sym0_p2_i", 10, obs_i[10], 1); chk("sym0_p2_q", 10, obs_q[10], 0);
    chk("sym0_valid_cnt", 0, count_v(0, 27), 16);

    // Symbol 0x8.
    new_test();
    fifo1.push_back(4'h8);
    add_burst(1, 8, 0, 0, 1, 0);
    run_window(23);
    chk("sym8_p0_i", 3, obs_i[3], 1); chk("sym8_p0_q", 3, obs_q[3], 0);
    chk("sym8_p1_i", 4, obs_i[4], 0); chk("sym8_p1_q", 4, obs_q[4], 0);

    // Symbol 0x1.
    new_test();
    fifo1.push_back(4'h1);
    add_burst(1, 1, 0, 0, 1, 0);
    run_window(23);
    chk("sym1_p0_i", 3, obs_i[3], 1); chk("sym1_p0_q", 3, obs_q[3], 1);
    chk("sym1_p1_i", 4, obs_i[4], 1); chk("sym1_p1_q", 4, obs_q[4], 0);

    // Back-to-back 0x0, 0x1, 0xF.
    new_test();
    fifo1.push_back(4'h0); fifo1.push_back(4'h1); fifo1.push_back(4'hF);
    add_burst(1, 0, 1, 15, 3, 0);
    run_window(55);
    chk("b2b_valid_cnt", 0, count_v(3, 50), 48);
    chk("b2b_start_cnt", 0, count_sr(0), 3);
    chk("b2b_read_cnt", 0, count_sr(1), 3);
    chk("b2b_pf0", 17, obs_r[17], 1);
    chk("b2b_pf1", 33, obs_r[33], 1);
    chk("symF_p0_i", 35, obs_i[35], 1); chk("symF_p0_q", 35, obs_q[35], 1);

    // Enable dropped at pair 5 with FIFO still non-empty.
    new_test();
    fifo1.push_back(4'h2); fifo1.push_back(4'h7);
    for (int unsigned c = 8; c < MAXC; c++) drv_en[c] = 0;
    add_burst(1, 2, 0, 0, 1, 0);
    run_window(23);
    chk("endrop_read_cnt", 0, count_sr(1), 1);
    chk("endrop_valid_cnt", 0, count_v(0, 22), 16);
    fifo1.delete();
    empty1 = 1'b1;

    // CHIP_DIV=4, reset during pair 9, then restart.
    new_test();
    sel = 1'b1;
    fifo4.push_back(4'h3); fifo4.push_back(4'h5);
    drv_rst[40] = 1;
    drv_en[41] = 0; drv_en[42] = 0;
    add_burst(4, 3, 0, 0, 1, 0);
    clear_from(41);
    add_burst(4, 5, 0, 0, 1, 43);
    run_window(114);
    chk("rst4_valid", 41, obs_v[41], 0);
    chk("rst4_chip_i", 41, obs_i[41] | obs_q[41], 0);
    chk("rst4_busy", 41, obs_b[41], 0);
    chk("restart_start", 46, obs_s[46], 1);
    chk("sym5_p0_i", 49, obs_i[49], 0); chk("sym5_p0_q", 49, obs_q[49], 0);
    chk("sym5_p1_i", 50, obs_i[50], 1); chk("sym5_p1_q", 50, obs_q[50], 1);
    chk("restart_valid_cnt", 0, count_v(41, 113), 64);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
